seq_shift_unit: RTL and testbench

- Multi-cycle shift responder for the NPC EXU, serving SLL/SRL/SRA (and immediate variants) through a valid/ready request/response handshake.
- The EXU is the initiator. This block accepts one operand/shamt/op request, shifts a working register by at most STEP bits per cycle, and returns the 32-bit result.
- It complements the combinational fixed-shamt shifter: variable shamt, registered, low area.
- Direction/arith selects use the same encoding as the existing shifter: l_or_r=1 selects left; a_or_l=1 selects arithmetic.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/seq_shift_unit_if.sv | 27 ++
 rtl/shift_step.sv | 30 +++
 rtl/seq_shift_unit.sv | 98 +++++++++
 tb/tb_seq_shift_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential shifter: FSM state encoding,
// op-select constants and the per-cycle step clamp.
package shift_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic SHIFT_LEFT  = 1'b1;
   localparam logic SHIFT_RIGHT = 1'b0;
   localparam logic SHIFT_ARITH = 1'b1;
   localparam logic SHIFT_LOGIC = 1'b0;

   function automatic int unsigned min_step(input int unsigned count, input int unsigned step);
      return (count < step) ? count : step;
   endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle between the EXU (master) and the shift unit (slave).
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the sender holds valid and payload until then.
interface seq_shift_unit_if #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_data;
   logic [SHW-1:0]  in_shamt;
   logic            in_l_or_r;
   logic            in_a_or_l;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;

   modport master (
      output in_valid, in_data, in_shamt, in_l_or_r, in_a_or_l, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_l_or_r, in_a_or_l, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/shift_step.sv
// One combinational shift stage of 0..STEP bits. Arithmetic right shifts fill
// from an externally supplied sign so the sign survives repeated steps.
module shift_step
   import shift_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 1,
   parameter int KW   = $clog2(STEP + 1)
) (
   input  logic [XLEN-1:0] data,
   input  logic [KW-1:0]   k,
   input  logic            l_or_r,
   input  logic            a_or_l,
   input  logic            sign_bit,
   output logic [XLEN-1:0] data_out
);

   logic [XLEN-1:0] fill_mask;

   always_comb begin
      fill_mask = ~({XLEN{1'b1}} >> k);
      data_out  = data >> k;
      if (l_or_r == SHIFT_LEFT) begin
         data_out = data << k;
      end else if (a_or_l == SHIFT_ARITH && sign_bit) begin
         data_out = (data >> k) | fill_mask;
      end
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle variable shifter: accepts one request, shifts a working register
// by up to STEP bits per cycle, then presents the result until it is taken.
module seq_shift_unit
   import shift_pkg::*;
#(
   parameter  int XLEN = 32,
   parameter  int STEP = 1,
   localparam int SHW  = $clog2(XLEN),
   localparam int KW   = $clog2(STEP + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   seq_shift_unit_if.slave       bus,
   output state_t                dbg_state
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] work_q, work_d;
   logic [SHW-1:0]  count_q, count_d;
   logic            l_or_r_q, l_or_r_d;
   logic            a_or_l_q, a_or_l_d;
   logic            sign_q, sign_d;

   logic [KW-1:0]   k;
   logic [XLEN-1:0] step_out;
   logic            accept;

   assign k = KW'(min_step(32'(count_q), STEP));

   shift_step #(.XLEN(XLEN), .STEP(STEP), .KW(KW)) u_step (
      .data     (work_q),
      .k        (k),
      .l_or_r   (l_or_r_q),
      .a_or_l   (a_or_l_q),
      .sign_bit (sign_q),
      .data_out (step_out)
   );

   always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      count_d  = count_q;
      l_or_r_d = l_or_r_q;
      a_or_l_d = a_or_l_q;
      sign_d   = sign_q;
      accept   = bus.in_valid && (state_q == S_IDLE) && !flush;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               work_d   = bus.in_data;
               count_d  = bus.in_shamt;
               l_or_r_d = bus.in_l_or_r;
               a_or_l_d = bus.in_a_or_l;
               sign_d   = bus.in_data[XLEN-1];
               state_d  = (bus.in_shamt == '0) ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            work_d  = step_out;
            count_d = count_q - SHW'(k);
            if (count_d == '0) state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Redirect wins over both handshakes; the working register is left as-is.
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         work_q   <= '0;
         count_q  <= '0;
         l_or_r_q <= 1'b0;
         a_or_l_q <= 1'b0;
         sign_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         work_q   <= work_d;
         count_q  <= count_d;
         l_or_r_q <= l_or_r_d;
         a_or_l_q <= a_or_l_d;
         sign_q   <= sign_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out_data  = work_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: a STEP=1 and a STEP=4 instance driven in turn,
// checked against a whole-word shift model and a ceil(shamt/STEP)+1 latency rule.
module tb_seq_shift_unit;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_l;
   logic        in_a;
   logic        out_ready;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   seq_shift_unit_if #(.XLEN(32)) if1 ();
   seq_shift_unit_if #(.XLEN(32)) if4 ();
   state_t st1, st4;
   logic   flush1, flush4;

   assign if1.in_valid  = in_valid & ~sel;
   assign if4.in_valid  = in_valid & sel;
   assign if1.out_ready = out_ready & ~sel;
   assign if4.out_ready = out_ready & sel;
   assign flush1        = flush & ~sel;
   assign flush4        = flush & sel;
   assign if1.in_data   = in_data;
   assign if4.in_data   = in_data;
   assign if1.in_shamt  = in_shamt;
   assign if4.in_shamt  = in_shamt;
   assign if1.in_l_or_r = in_l;
   assign if4.in_l_or_r = in_l;
   assign if1.in_a_or_l = in_a;
   assign if4.in_a_or_l = in_a;

   seq_shift_unit #(.XLEN(32), .STEP(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush1), .bus(if1.slave), .dbg_state(st1)
   );
   seq_shift_unit #(.XLEN(32), .STEP(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush4), .bus(if4.slave), .dbg_state(st4)
   );

   logic        o_in_ready, o_out_valid;
   logic [31:0] o_out_data;
   state_t      o_state;
   assign o_in_ready  = sel ? if4.in_ready  : if1.in_ready;
   assign o_out_valid = sel ? if4.out_valid : if1.out_valid;
   assign o_out_data  = sel ? if4.out_data  : if1.out_data;
   assign o_state     = sel ? st4 : st1;

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input int sh, input logic l, input logic a);
      if (l == SHIFT_LEFT) return d << sh;
      else if (a == SHIFT_ARITH) return 32'($signed(d) >>> sh);
      else return d >> sh;
   endfunction

   // Called just after a negedge; returns just after a negedge with the unit idle.
   task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic l,
                         input logic a, input int hold);
      int step, lat, n, exp_lat;
      logic [31:0] held;
      step = sel ? 4 : 1;
      exp_q.push_back(model(d, int'(sh), l, a));
      exp_lat = (int'(sh) + step - 1) / step + 1;
      n = 0;
      while (!o_in_ready && n < 64) begin
         @(negedge clk);
         n++;
      end
      check("idle_in_ready", 32'(o_in_ready), 32'(1));
      in_data = d; in_shamt = sh; in_l = l; in_a = a; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      in_shamt = 5'($urandom_range(0, 31));
      in_l     = 1'($urandom_range(0, 1));
      in_a     = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat = 1;
      while (!o_out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("out_data", o_out_data, exp_q.pop_front());
      for (int h = 0; h < hold; h++) begin
         held = o_out_data;
         @(negedge clk);
         check("hold_data", o_out_data, held);
         check("hold_in_ready", 32'(o_in_ready), 32'(0));
         check("hold_out_valid", 32'(o_out_valid), 32'(1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("post_hs_out_valid", 32'(o_out_valid), 32'(0));
      check("post_hs_in_ready", 32'(o_in_ready), 32'(1));
   endtask

   initial begin
      int seen;
      rst = 1'b1; sel = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_shamt = '0; in_l = 1'b0; in_a = 1'b0; out_ready = 1'b0;

      // Reset state of both instances.
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         check("rst_in_ready", 32'(o_in_ready), 32'(1));
         check("rst_out_valid", 32'(o_out_valid), 32'(0));
         check("rst_out_data", o_out_data, 32'h0);
         check("rst_state", 32'(o_state), 32'(S_IDLE));
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed STEP=1 cases.
      run_op(32'h8000_0000, 5'd4, SHIFT_RIGHT, SHIFT_ARITH, 0);
      run_op(32'h0000_0001, 5'd31, SHIFT_LEFT, SHIFT_LOGIC, 0);
      run_op(32'h8000_0000, 5'd31, SHIFT_RIGHT, SHIFT_LOGIC, 0);
      run_op(32'hDEAD_BEEF, 5'd0, SHIFT_RIGHT, SHIFT_ARITH, 0);
      run_op(32'h1234_5678, 5'd5, SHIFT_RIGHT, SHIFT_LOGIC, 3);
      run_op(32'hF000_000F, 5'd3, SHIFT_LEFT, SHIFT_ARITH, 0);

      // Flush in the second BUSY cycle: back to idle, no result ever appears.
      in_data = 32'hFFFF_0000; in_shamt = 5'd8; in_l = SHIFT_RIGHT; in_a = SHIFT_LOGIC;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_pre_state", 32'(o_state), 32'(S_BUSY));
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_state", 32'(o_state), 32'(S_IDLE));
      check("flush_in_ready", 32'(o_in_ready), 32'(1));
      check("flush_out_valid", 32'(o_out_valid), 32'(0));
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (o_out_valid) seen++;
      end
      check("flush_no_result", 32'(seen), 32'(0));

      // Flush beats a same-cycle accept.
      in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_vs_accept", 32'(o_state), 32'(S_IDLE));

      // Async reset mid-BUSY takes effect without a clock edge.
      in_data = 32'hFFFF_0000; in_shamt = 5'd8; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", 32'(o_in_ready), 32'(1));
      check("arst_out_valid", 32'(o_out_valid), 32'(0));
      check("arst_out_data", o_out_data, 32'h0);
      check("arst_state", 32'(o_state), 32'(S_IDLE));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Randomized STEP=1 traffic.
      repeat (15)
         run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2));

      // STEP=4 instance: directed then random.
      sel = 1'b1;
      #1;
      run_op(32'h0000_000F, 5'd10, SHIFT_LEFT, SHIFT_LOGIC, 0);
      run_op(32'h8765_4321, 5'd31, SHIFT_RIGHT, SHIFT_ARITH, 1);
      run_op(32'hCAFE_F00D, 5'd0, SHIFT_LEFT, SHIFT_LOGIC, 0);
      repeat (15)
         run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
